// File: rtl/pzc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : pzc_pkg                                                      |
// | Description : Shared helpers for the multi-channel pole-zero cancellation  |
// |               filter: derived-width functions and the saturation clamp     |
// |               used when PZC_SAT_EN is defined.                             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package pzc_pkg;

  // Widest intermediate that sat_clip accepts; NBITS_OUT+MBITS+2 must fit.
  localparam int SAT_CLIP_W = 64;

  // Channel index width; a single channel still gets a 1-bit index.
  function automatic int calc_ch_w(input int nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction

  // Shift that divides the correction sum by K_CORR (K_CORR is a power of 2).
  function automatic int calc_shift(input int k_corr);
    return $clog2(k_corr);
  endfunction

  // Clamp a signed value into the signed range of 'width' bits.
  function automatic logic signed [SAT_CLIP_W-1:0] sat_clip(
    input logic signed [SAT_CLIP_W-1:0] value,
    input int                           width
  );
    logic signed [SAT_CLIP_W-1:0] hi;
    logic signed [SAT_CLIP_W-1:0] lo;
    hi = (SAT_CLIP_W'(1) <<< (width - 1)) - SAT_CLIP_W'(1);
    lo = ~hi;
    if (value > hi) begin
      return hi;
    end else if (value < lo) begin
      return lo;
    end
    return value;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pzc_chan_state.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pzc_chan_state                                               |
// | Description : NCH-entry per-channel state register file. Combinational     |
// |               read port, single synchronous write port, synchronous clear  |
// |               of every entry, asynchronous active-high reset.              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module pzc_chan_state
  import pzc_pkg::*;
#(
  parameter int NCH     = 4,
  parameter int STATE_W = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clear_i,
  input  logic [calc_ch_w(NCH)-1:0]   rd_ch_i,
  output logic [STATE_W-1:0]          rd_data_o,
  input  logic                        wr_en_i,
  input  logic [calc_ch_w(NCH)-1:0]   wr_ch_i,
  input  logic [STATE_W-1:0]          wr_data_i
);

  localparam int CH_W = calc_ch_w(NCH);

  logic [STATE_W-1:0] mem_q [NCH];

  // State storage: clear wipes every channel and wins over a pending write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (clear_i) begin
      for (int i = 0; i < NCH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en_i) begin
      for (int i = 0; i < NCH; i++) begin
        if (wr_ch_i == CH_W'(i)) begin
          mem_q[i] <= wr_data_i;
        end
      end
    end
  end

  // Read mux; an index with no matching entry reads as zero.
  always_comb begin
    rd_data_o = '0;
    for (int i = 0; i < NCH; i++) begin
      if (rd_ch_i == CH_W'(i)) begin
        rd_data_o = mem_q[i];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/pzc_baseline_mc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pzc_baseline_mc                                              |
// | Description : Time-multiplexed multi-channel pole-zero cancellation with   |
// |               automatic baseline restoration. S0 captures the sample, S1   |
// |               reads, updates and writes back channel state in one cycle    |
// |               and registers the result (2-cycle latency, 1 sample/cycle).  |
// |               Build option: define PZC_SAT_EN to clamp y/acc instead of    |
// |               wrapping them.                                               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module pzc_baseline_mc
  import pzc_pkg::*;
#(
  parameter int NBITS_IN  = 12,
  parameter int NBITS_OUT = 28,
  parameter int MBITS     = 10,
  parameter int NCH       = 4,
  parameter int K_CORR    = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              clear,
  input  logic                              corr_en,
  input  logic [MBITS-1:0]                  m_factor,
  input  logic                              in_valid,
  input  logic [calc_ch_w(NCH)-1:0]         in_ch,
  input  logic signed [NBITS_IN-1:0]        in,
  output logic                              out_valid,
  output logic [calc_ch_w(NCH)-1:0]         out_ch,
  output logic signed [NBITS_OUT-1:0]       out
);

  localparam int CH_W  = calc_ch_w(NCH);
  localparam int SHIFT = calc_shift(K_CORR);
  localparam int SUM_W = NBITS_OUT + SHIFT;   // K_CORR negative y's always fit
  localparam int CNT_W = SHIFT;               // counts 0..K_CORR-1 between corrections
`ifdef PZC_SAT_EN
  localparam int CALC_W = NBITS_OUT + MBITS + 2;
`else
  localparam int CALC_W = NBITS_OUT;          // modular arithmetic wraps for free
`endif

  typedef struct packed {
    logic signed [NBITS_OUT-1:0] acc;
    logic signed [SUM_W-1:0]     sum;
    logic signed [NBITS_OUT-1:0] corr;
    logic [CNT_W-1:0]            cnt;
  } pzc_state_t;

  localparam int STATE_W = $bits(pzc_state_t);

  // S0 capture registers
  logic                        s0_valid_q;
  logic [CH_W-1:0]             s0_ch_q;
  logic signed [NBITS_IN-1:0]  s0_x_q;
  logic [MBITS-1:0]            s0_m_q;

  // S1 result registers
  logic                        out_valid_q;
  logic [CH_W-1:0]             out_ch_q;
  logic signed [NBITS_OUT-1:0] out_q;

  logic                        w_ch_ok;
  logic [STATE_W-1:0]          w_rd_raw;
  pzc_state_t                  w_cur;
  pzc_state_t                  w_next;
  logic signed [CALC_W-1:0]    w_x_ext;
  logic signed [CALC_W-1:0]    w_m1_ext;
  logic signed [CALC_W-1:0]    w_acc_ext;
  logic signed [CALC_W-1:0]    w_corr_ext;
  logic signed [CALC_W-1:0]    w_y_calc;
  logic signed [CALC_W-1:0]    w_acc_calc;
  logic signed [NBITS_OUT-1:0] w_y;
  logic signed [NBITS_OUT-1:0] w_acc_new;
  logic signed [SUM_W-1:0]     w_sum_new;
  logic [CNT_W:0]              w_cnt_inc;
  logic                        w_cnt_full;

  // Out-of-range channel indices only exist when NCH is not a power of two.
  if (NCH < (1 << CH_W)) begin : g_ch_range
    assign w_ch_ok = (in_ch < CH_W'(NCH));
  end else begin : g_ch_full
    assign w_ch_ok = 1'b1;
  end

  // S0: capture the sample; clear drops whatever arrives with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0_valid_q <= 1'b0;
      s0_ch_q    <= '0;
      s0_x_q     <= '0;
      s0_m_q     <= '0;
    end else begin
      s0_valid_q <= in_valid & w_ch_ok & ~clear;
      if (in_valid) begin
        s0_ch_q <= in_ch;
        s0_x_q  <= in;
        s0_m_q  <= m_factor;
      end
    end
  end

  pzc_chan_state #(
    .NCH     (NCH),
    .STATE_W (STATE_W)
  ) u_state (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (clear),
    .rd_ch_i   (s0_ch_q),
    .rd_data_o (w_rd_raw),
    .wr_en_i   (s0_valid_q),
    .wr_ch_i   (s0_ch_q),
    .wr_data_i (w_next)
  );

  assign w_cur = w_rd_raw;

  // S1 arithmetic: sign-extend samples/state, zero-extend m before adding 1.
  assign w_x_ext    = CALC_W'(s0_x_q);
  assign w_m1_ext   = CALC_W'(s0_m_q) + CALC_W'(1);
  assign w_acc_ext  = CALC_W'($signed(w_cur.acc));
  assign w_corr_ext = CALC_W'($signed(w_cur.corr));
  assign w_y_calc   = w_x_ext * w_m1_ext + w_acc_ext - w_corr_ext;
  assign w_acc_calc = w_acc_ext + w_x_ext - w_corr_ext;

`ifdef PZC_SAT_EN
  assign w_y       = NBITS_OUT'(sat_clip(SAT_CLIP_W'(w_y_calc), NBITS_OUT));
  assign w_acc_new = NBITS_OUT'(sat_clip(SAT_CLIP_W'(w_acc_calc), NBITS_OUT));
`else
  assign w_y       = w_y_calc;
  assign w_acc_new = w_acc_calc;
`endif

  // The current negative y is part of the sum that may trigger a correction.
  assign w_sum_new  = $signed(w_cur.sum) + SUM_W'(w_y);
  assign w_cnt_inc  = {1'b0, w_cur.cnt} + (CNT_W + 1)'(1);
  assign w_cnt_full = (w_cnt_inc == (CNT_W + 1)'(K_CORR));

  // Next channel state: a correction lives for exactly one later sample.
  always_comb begin
    w_next      = w_cur;
    w_next.acc  = w_acc_new;
    w_next.corr = '0;
    if (!corr_en) begin
      w_next.cnt = '0;
      w_next.sum = '0;
    end else if (w_y[NBITS_OUT-1]) begin
      if (w_cnt_full) begin
        w_next.corr = NBITS_OUT'(w_sum_new >>> SHIFT);
        w_next.cnt  = '0;
        w_next.sum  = '0;
      end else begin
        w_next.cnt = w_cnt_inc[CNT_W-1:0];
        w_next.sum = w_sum_new;
      end
    end
  end

  // Result register; clear suppresses the result of the sample in S1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      out_q       <= '0;
    end else if (clear) begin
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= s0_valid_q;
      if (s0_valid_q) begin
        out_ch_q <= s0_ch_q;
        out_q    <= w_y;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_ch    = out_ch_q;
  assign out       = out_q;

endmodule
`default_nettype wire

// File: tb/tb_pzc_baseline_mc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_pzc_baseline_mc                                           |
// | Description : Self-checking bench for pzc_baseline_mc: hand-computed       |
// |               vector table, random traffic against a behavioural model,    |
// |               reset sequences. Honours PZC_SAT_EN like the design.         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_pzc_baseline_mc;

  localparam int NBITS_IN  = 12;
  localparam int NBITS_OUT = 16;
  localparam int MBITS     = 10;
  localparam int NCH       = 3;   // 2-bit channel index so index 3 is out of range
  localparam int K_CORR    = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              clear;
  logic              corr_en;
  logic [MBITS-1:0]  m_factor;
  logic              in_valid;
  logic [1:0]        in_ch;
  logic signed [NBITS_IN-1:0]  in_s;
  logic              out_valid;
  logic [1:0]        out_ch;
  logic signed [NBITS_OUT-1:0] out_s;

  pzc_baseline_mc #(
    .NBITS_IN  (NBITS_IN),
    .NBITS_OUT (NBITS_OUT),
    .MBITS     (MBITS),
    .NCH       (NCH),
    .K_CORR    (K_CORR)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .corr_en   (corr_en),
    .m_factor  (m_factor),
    .in_valid  (in_valid),
    .in_ch     (in_ch),
    .in        (in_s),
    .out_valid (out_valid),
    .out_ch    (out_ch),
    .out       (out_s)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: per-channel state as plain integers.
  longint macc [NCH];
  longint mcorr[NCH];
  longint msum [NCH];
  int     mcnt [NCH];

  // Sample currently sitting between capture and compute.
  bit     pend_v;
  int     pend_ch, pend_x, pend_m;

  function automatic longint fit(input longint v);
    longint hi;
    longint lo;
    longint span;
    longint r;
    hi   = (longint'(1) << (NBITS_OUT - 1)) - 1;
    lo   = -(longint'(1) << (NBITS_OUT - 1));
    span = longint'(1) << NBITS_OUT;
`ifdef PZC_SAT_EN
    r = (v > hi) ? hi : ((v < lo) ? lo : v);
`else
    r = v % span;
    if (r < 0) r = r + span;
    if (r > hi) r = r - span;
`endif
    return r;
  endfunction

  function automatic longint floor_div(input longint a, input longint b);
    return (a >= 0) ? a / b : -((-a + b - 1) / b);
  endfunction

  function automatic void model_zero();
    for (int i = 0; i < NCH; i++) begin
      macc[i] = 0; mcorr[i] = 0; msum[i] = 0; mcnt[i] = 0;
    end
  endfunction

  function automatic longint model_step(input int c, input int x, input int m, input bit ce);
    longint y;
    y       = fit(longint'(x) * longint'(m + 1) + macc[c] - mcorr[c]);
    macc[c] = fit(longint'(x) + macc[c] - mcorr[c]);
    mcorr[c] = 0;
    if (!ce) begin
      mcnt[c] = 0;
      msum[c] = 0;
    end else if (y < 0) begin
      mcnt[c] = mcnt[c] + 1;
      msum[c] = msum[c] + y;
      if (mcnt[c] == K_CORR) begin
        mcorr[c] = floor_div(msum[c], K_CORR);
        mcnt[c]  = 0;
        msum[c]  = 0;
      end
    end
    return y;
  endfunction

  task automatic cmp_out(input string name, input bit ev, input int ech, input longint ey);
    n_chk++;
    if (out_valid !== ev ||
        (ev && (int'(out_ch) != ech || longint'(out_s) != ey))) begin
      $display("FAIL %s t=%0t: got valid=%0b ch=%0d out=%0d, required valid=%0b ch=%0d out=%0d",
               name, $time, out_valid, out_ch, out_s, ev, ech, ey);
    end else begin
      n_pass++;
    end
  endtask

  task automatic check_idle_zero(input string name);
    n_chk++;
    if (out_valid !== 1'b0 || out_s !== '0 || out_ch !== '0) begin
      $display("FAIL %s t=%0t: got valid=%0b ch=%0d out=%0d, required valid=0 ch=0 out=0",
               name, $time, out_valid, out_ch, out_s);
    end else begin
      n_pass++;
    end
  endtask

  // One clock of stimulus; the model tracks the sample that is in compute now.
  task automatic cycle(input bit v, input int ch, input int x, input int m,
                       input bit ce, input bit clr);
    bit     ev;
    int     ech;
    longint ey;
    in_valid = v;
    in_ch    = ch[1:0];
    in_s     = x[NBITS_IN-1:0];
    m_factor = m[MBITS-1:0];
    corr_en  = ce;
    clear    = clr;
    ev  = 1'b0;
    ech = 0;
    ey  = 0;
    if (clr) begin
      model_zero();
      pend_v = 1'b0;
    end else begin
      if (pend_v) begin
        ey  = model_step(pend_ch, pend_x, pend_m, ce);
        ev  = 1'b1;
        ech = pend_ch;
      end
      pend_v  = v && (ch < NCH);
      pend_ch = ch;
      pend_x  = x;
      pend_m  = m;
    end
    @(posedge clk);
    #1;
    cmp_out("model", ev, ech, ey);
  endtask

  typedef struct {
    bit v; int ch; int x; int m; bit ce; bit clr;
    bit ev; int ech; int ey;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input bit v, input int ch, input int x, input int m, input bit ce,
                     input bit clr, input bit ev, input int ech, input int ey);
    vec_t t;
    t.v = v; t.ch = ch; t.x = x; t.m = m; t.ce = ce; t.clr = clr;
    t.ev = ev; t.ech = ech; t.ey = ey;
    tbl.push_back(t);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  bit rv, rce, rclr;
  int rch, rx, rm;

  initial begin
    rst = 1'b1; clear = 1'b0; corr_en = 1'b0; m_factor = '0;
    in_valid = 1'b0; in_ch = '0; in_s = '0;
    model_zero();
    pend_v = 1'b0;

    // Each row's expected output is the result visible after that row's clock.
    // Step from fresh reset state, m=3.
    add(1,0,10,3,0,0, 0,0,0);
    add(1,0,10,3,0,0, 1,0,40);
    add(1,0,10,3,0,0, 1,0,50);
    add(0,0,0,3,0,0,  1,0,60);
    add(0,0,0,3,0,0,  0,0,0);
    // Baseline restoration, m=0, corr_en=1.
    add(0,0,0,0,1,1,  0,0,0);
    add(1,0,-1,0,1,0, 0,0,0);
    add(1,0,-1,0,1,0, 1,0,-1);
    add(1,0,-1,0,1,0, 1,0,-2);
    add(1,0,-1,0,1,0, 1,0,-3);
    add(1,0,0,0,1,0,  1,0,-4);
    add(1,0,0,0,1,0,  1,0,-1);
    add(0,0,0,0,1,0,  1,0,-1);
    add(0,0,0,0,1,0,  0,0,0);
    // Same stimulus with corr_en=0: pure PZC.
    add(0,0,0,0,0,1,  0,0,0);
    add(1,0,-1,0,0,0, 0,0,0);
    add(1,0,-1,0,0,0, 1,0,-1);
    add(1,0,-1,0,0,0, 1,0,-2);
    add(1,0,-1,0,0,0, 1,0,-3);
    add(1,0,0,0,0,0,  1,0,-4);
    add(0,0,0,0,0,0,  1,0,-4);
    // Interleaved channels, out-of-range index, ch1 correction isolated from ch0.
    add(0,0,0,3,1,1,  0,0,0);
    add(1,0,10,3,1,0, 0,0,0);
    add(1,1,-5,3,1,0, 1,0,40);
    add(1,0,10,3,1,0, 1,1,-20);
    add(1,1,-5,3,1,0, 1,0,50);
    add(1,3,7,3,1,0,  1,1,-25);
    add(0,0,0,3,1,0,  0,0,0);
    add(1,1,-5,3,1,0, 0,0,0);
    add(1,1,-5,3,1,0, 1,1,-30);
    add(1,0,10,3,1,0, 1,1,-35);
    add(1,1,0,3,1,0,  1,0,60);
    add(0,0,0,3,1,0,  1,1,8);
    // Clear in the middle of a burst.
    add(0,0,0,3,0,1,  0,0,0);
    add(1,0,10,3,0,0, 0,0,0);
    add(1,0,10,3,0,0, 1,0,40);
    add(1,0,10,3,0,1, 0,0,0);
    add(1,0,10,3,0,0, 0,0,0);
    add(0,0,0,3,0,0,  1,0,40);
    add(0,0,0,3,0,0,  0,0,0);
    // Overflow of y.
    add(0,0,0,0,0,1,  0,0,0);
    add(1,0,2047,1023,0,0, 0,0,0);
`ifdef PZC_SAT_EN
    add(1,0,2047,1023,0,0, 1,0,32767);
    add(0,0,0,0,0,0,       1,0,32767);
`else
    add(1,0,2047,1023,0,0, 1,0,-1024);
    add(0,0,0,0,0,0,       1,0,1023);
`endif

    // Reset held while in_valid toggles.
    for (int i = 0; i < 4; i++) begin
      in_valid = (i % 2 == 0);
      in_s     = 12'sd100;
      @(posedge clk);
      #1;
      check_idle_zero("reset_hold");
    end
    in_valid = 1'b0;
    rst = 1'b0;

    for (int r = 0; r < tbl.size(); r++) begin
      cycle(tbl[r].v, tbl[r].ch, tbl[r].x, tbl[r].m, tbl[r].ce, tbl[r].clr);
      cmp_out($sformatf("tbl[%0d]", r), tbl[r].ev, tbl[r].ech, longint'(tbl[r].ey));
    end

    // Random traffic, biased toward small values so corrections fire often.
    rce = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      rv  = ($urandom_range(0, 3) != 0);
      rch = int'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 0) rx = int'($urandom_range(0, 15)) - 8;
      else                           rx = int'($urandom_range(0, 4095)) - 2048;
      if ($urandom_range(0, 3) == 0) rm = int'($urandom_range(0, 1023));
      else                           rm = int'($urandom_range(0, 3));
      if ($urandom_range(0, 99) == 0) rce = ~rce;
      rclr = ($urandom_range(0, 63) == 0);
      cycle(rv, rch, rx, rm, rce, rclr);
    end

    // Reset in the middle of traffic: output disappears at once, nothing pending survives.
    cycle(1, 0, 100, 2, 0, 0);
    cycle(1, 1, 50, 2, 0, 0);
    rst = 1'b1;
    #1;
    check_idle_zero("reset_async");
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_zero();
    pend_v = 1'b0;
    cycle(0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
    cycle(1, 2, 10, 3, 0, 0);
    cycle(0, 0, 0, 3, 0, 0);
    cmp_out("post_reset", 1'b1, 2, 40);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
